// File: rtl/shift_sequencer.sv
// shift_sequencer: sequenced shifter for the ALU datapath. It is the area-lean alternative
// to the combinational barrel shifter and moves the operand one bit position per clock.
//
// Ports:
//   clk_i       rising-edge clock
//   reset_i     synchronous, active-high reset; beats every other condition in any state
//   start_i     request; sampled only while idle
//   funct_i     MIPS funct: SLL=6'b000000, SRL=6'b000010, SRA=6'b000011
//   data_a_i    operand to shift
//   data_b_i    shift amount, full unsigned value, clamped to Width
//   busy_o      high whenever the sequencer is not idle
//   done_o      one-cycle completion pulse
//   err_o       last accepted funct was unsupported; valid with done_o, held until next accept
//   data_out_o  result; stable from done_o until the next accepted start
//
// Timing, counting the accept cycle as cycle 0 and N as the clamped amount:
//   busy_o is high in cycles 1..N+1, done_o only in cycle N+1. N=0 and unsupported funct
//   finish in cycle 1. All outputs come straight from flops.

module shift_sequencer #(
    parameter int unsigned Width = 32,
    parameter int unsigned CntW  = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [5:0]       funct_i,
    input  logic [Width-1:0] data_a_i,
    input  logic [Width-1:0] data_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [Width-1:0] data_out_o
);

    localparam logic [5:0] FunctSll = 6'b000000;
    localparam logic [5:0] FunctSrl = 6'b000010;
    localparam logic [5:0] FunctSra = 6'b000011;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e            state_q;
    logic [Width-1:0]  r_q;
    logic [CntW-1:0]   cnt_q;
    logic [5:0]        op_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    // Request decode, only meaningful while idle.
    logic              funct_ok;
    logic [CntW-1:0]   amt_clamped;

    always_comb begin
        funct_ok = (funct_i == FunctSll) || (funct_i == FunctSrl) || (funct_i == FunctSra);
    end

    // Any amount >= Width, including one with high bits set, saturates at Width so that a
    // full shift still yields the architecturally expected zero / sign fill.
    always_comb begin
        amt_clamped = data_b_i[CntW-1:0];
        if (data_b_i >= Width'(Width)) begin
            amt_clamped = CntW'(Width);
        end
    end

    // Single registered FSM: busy/done are computed alongside the next state so that the
    // outputs are pure flop outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            r_q     <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start_i) begin
                        op_q   <= funct_i;
                        busy_q <= 1'b1;
                        if (!funct_ok) begin
                            // Unsupported op: report immediately with a zero result.
                            r_q     <= '0;
                            cnt_q   <= '0;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            r_q   <= data_a_i;
                            cnt_q <= amt_clamped;
                            err_q <= 1'b0;
                            if (amt_clamped == '0) begin
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                state_q <= StShift;
                            end
                        end
                    end
                end

                StShift: begin
                    unique case (op_q)
                        FunctSll: r_q <= r_q << 1;
                        FunctSrl: r_q <= r_q >> 1;
                        FunctSra: r_q <= {r_q[Width-1], r_q[Width-1:1]};
                        default:  r_q <= r_q;
                    endcase
                    cnt_q <= cnt_q - CntW'(1);
                    // Last shift happens in this cycle; the result is final in DONE.
                    if (cnt_q == CntW'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end

                StDone: begin
                    // start_i is deliberately ignored here; a held request is taken in IDLE.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign data_out_o = r_q;

    // Structural invariants of the registered outputs.
    a_busy_matches_state : assert property (
        @(posedge clk_i) disable iff (reset_i) busy_q == (state_q != StIdle)
    );
    a_done_only_in_done : assert property (
        @(posedge clk_i) disable iff (reset_i) done_q == (state_q == StDone)
    );
    a_cnt_in_range : assert property (
        @(posedge clk_i) disable iff (reset_i) cnt_q <= CntW'(Width)
    );

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam logic [5:0] FSll = 6'b000000;
    localparam logic [5:0] FSrl = 6'b000010;
    localparam logic [5:0] FSra = 6'b000011;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] dout;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    shift_sequencer #(
        .Width (32),
        .CntW  (6)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .funct_i    (funct),
        .data_a_i   (a),
        .data_b_i   (b),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .data_out_o (dout)
    );

    typedef struct {
        string       name;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        e;
        int          lat;   // cycle of the done pulse, counted from the accept cycle
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input string name, input logic [5:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] out, input logic e,
                       input int lat);
        vec_t v;
        v.name = name; v.f = f; v.a = av; v.b = bv; v.out = out; v.e = e; v.lat = lat;
        vecs.push_back(v);
    endtask

    // One request from accept to the idle cycle after done; inputs are scrambled right
    // after accept so any late sampling of operands shows up in the result.
    task automatic run_op(input vec_t v);
        logic busy_ok;
        logic done_ok;
        @(negedge clk);
        start = 1'b1; funct = v.f; a = v.a; b = v.b;
        @(negedge clk);
        start = 1'b0; funct = 6'b111111; a = ~v.a; b = v.b ^ 32'h5;
        check({v.name, " err_at_cycle1"}, 32'(err), 32'(v.e));
        busy_ok = 1'b1;
        done_ok = 1'b1;
        for (int c = 1; c <= v.lat; c++) begin
            if (c > 1) @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== (c == v.lat)) done_ok = 1'b0;
        end
        check({v.name, " busy_window"}, 32'(busy_ok), 32'd1);
        check({v.name, " done_timing"}, 32'(done_ok), 32'd1);
        check({v.name, " data_out"}, dout, v.out);
        check({v.name, " err"}, 32'(err), 32'(v.e));
        @(negedge clk);
        check({v.name, " idle_busy_done"}, {30'd0, busy, done}, 32'd0);
        check({v.name, " held_out"}, dout, v.out);
    endtask

    initial begin
        logic seen;
        logic busy_ok;

        reset = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0;

        add("srl4",      FSrl, 32'h8000_0000, 32'd4,          32'h0800_0000, 1'b0, 5);
        add("sra4",      FSra, 32'h8000_0000, 32'd4,          32'hF800_0000, 1'b0, 5);
        add("sll31",     FSll, 32'h0000_0001, 32'd31,         32'h8000_0000, 1'b0, 32);
        add("sra_clamp", FSra, 32'h8000_0001, 32'h0000_0100,  32'hFFFF_FFFF, 1'b0, 33);
        add("srl_zero",  FSrl, 32'h1234_5678, 32'd0,          32'h1234_5678, 1'b0, 1);
        add("bad_funct", 6'b100000, 32'hDEAD_BEEF, 32'd3,     32'h0000_0000, 1'b1, 1);
        add("sll4_clr",  FSll, 32'hF0F0_F0F0, 32'd4,          32'h0F0F_0F00, 1'b0, 5);
        add("sra32_pos", FSra, 32'h7FFF_FFFF, 32'd32,         32'h0000_0000, 1'b0, 33);
        add("srl_huge",  FSrl, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 33);
        add("sll1",      FSll, 32'h8000_0001, 32'd1,          32'h0000_0002, 1'b0, 2);
        add("sra8",      FSra, 32'h8765_4321, 32'd8,          32'hFF87_6543, 1'b0, 9);
        add("srl31",     FSrl, 32'h8765_4321, 32'd31,         32'h0000_0001, 1'b0, 32);
        add("sll32",     FSll, 32'hFFFF_FFFF, 32'd32,         32'h0000_0000, 1'b0, 33);
        add("bad_funct1", 6'b000001, 32'h1111_1111, 32'd0,    32'h0000_0000, 1'b1, 1);

        repeat (3) @(negedge clk);
        check("reset_flags", {29'd0, busy, done, err}, 32'd0);
        check("reset_out", dout, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset while idle with err set clears it.
        check("err_held_idle", 32'(err), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_clears_err", 32'(err), 32'd0);

        // Reset in cycle 4 of an 8-bit SRL: abort without a done pulse.
        @(negedge clk);
        start = 1'b1; funct = FSrl; a = 32'hFFFF_0000; b = 32'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_flags", {29'd0, busy, done, err}, 32'd0);
        check("abort_out", dout, 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // Start pulsed with other operands in cycles 2-3 is ignored, not queued.
        @(negedge clk);
        start = 1'b1; funct = FSrl; a = 32'h8000_0000; b = 32'd4;
        @(negedge clk);                                       // cycle 1
        start = 1'b0;
        @(negedge clk);                                       // cycle 2
        start = 1'b1; funct = FSll; a = 32'hFFFF_FFFF; b = 32'd1;
        @(negedge clk);                                       // cycle 3
        @(negedge clk);                                       // cycle 4
        start = 1'b0;
        @(negedge clk);                                       // cycle 5
        check("ignore_done", 32'(done), 32'd1);
        check("ignore_out", dout, 32'h0800_0000);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) seen = 1'b1;
        end
        check("ignore_not_queued", 32'(seen), 32'd0);
        check("ignore_out_held", dout, 32'h0800_0000);

        // Start held continuously: second accept in cycle 6.
        @(negedge clk);
        start = 1'b1; funct = FSrl; a = 32'h8000_0000; b = 32'd4;
        busy_ok = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== (c == 5)) busy_ok = 1'b0;
        end
        check("held_first_op", 32'(busy_ok), 32'd1);
        check("held_first_out", dout, 32'h0800_0000);
        @(negedge clk);                                       // cycle 6, back in idle
        check("held_c6_idle", {30'd0, busy, done}, 32'd0);
        funct = FSll; a = 32'h0000_0001; b = 32'd2;
        @(negedge clk);                                       // cycle 7
        start = 1'b0;
        check("held_c7_busy", 32'(busy), 32'd1);
        @(negedge clk);                                       // cycle 8
        check("held_c8_no_done", 32'(done), 32'd0);
        @(negedge clk);                                       // cycle 9
        check("held_c9_done", 32'(done), 32'd1);
        check("held_second_out", dout, 32'h0000_0004);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
